// File: rtl/buffer_status_pkg.sv
// Shared constants and helpers for the buffer-status display pipeline.
// sat_inc is also used by the VGA block when it renders the counters.
package buffer_status_pkg;
    localparam int NUM_BUF = 4;
    localparam int DEPTH   = 6;
    localparam int DATA_W  = 4;
    localparam int CNT_W   = 8;
    localparam int OCC_W   = 3;

    localparam logic [DATA_W-1:0] EMPTY_SLOT = '0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] i_val);
        return (i_val == '1) ? i_val : i_val + CNT_W'(1);
    endfunction
endpackage

// File: rtl/buffer_status_core_if.sv
// Packet write / read request and read response bundle of buffer_status_core.
interface buffer_status_core_if;
    import buffer_status_pkg::*;

    logic              i_wr_valid;
    logic [1:0]        i_wr_buf;
    logic [DATA_W-1:0] i_wr_data;
    logic              i_rd_valid;
    logic [1:0]        i_rd_buf;
    logic              o_rd_valid;
    logic [DATA_W-1:0] o_rd_data;
    logic              o_rd_err;

    modport master (
        output i_wr_valid, i_wr_buf, i_wr_data, i_rd_valid, i_rd_buf,
        input  o_rd_valid, o_rd_data, o_rd_err
    );

    modport slave (
        input  i_wr_valid, i_wr_buf, i_wr_data, i_rd_valid, i_rd_buf,
        output o_rd_valid, o_rd_data, o_rd_err
    );
endinterface

// File: rtl/buf_queue.sv
// One DEPTH-deep shift queue: slot 0 is the head, unused slots hold EMPTY_SLOT.
// Exposes its next state so the top can snapshot post-update contents.
module buf_queue
    import buffer_status_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [DATA_W-1:0]        i_data,
    output logic [OCC_W-1:0]         o_occ,
    output logic [DATA_W-1:0]        o_head,
    output logic [OCC_W-1:0]         o_nxt_occ,
    output logic [DEPTH*DATA_W-1:0]  o_nxt_slots
);
    logic [DATA_W-1:0] r_slots [DEPTH];
    logic [OCC_W-1:0]  r_occ;
    logic [DATA_W-1:0] w_nxt   [DEPTH];
    logic [OCC_W-1:0]  w_occ_pop;
    logic [OCC_W-1:0]  w_nxt_occ;

    // Pop shifts first, then push lands at the post-pop tail.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_nxt[i] = r_slots[i];
        end
        w_occ_pop = r_occ;
        if (i_pop) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                w_nxt[i] = r_slots[i+1];
            end
            w_nxt[DEPTH-1] = EMPTY_SLOT;
            w_occ_pop      = r_occ - OCC_W'(1);
        end
        w_nxt_occ = w_occ_pop;
        if (i_push) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (OCC_W'(i) == w_occ_pop) begin
                    w_nxt[i] = i_data;
                end
            end
            w_nxt_occ = w_occ_pop + OCC_W'(1);
        end
    end

    always_comb begin
        o_nxt_slots = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            o_nxt_slots[i*DATA_W +: DATA_W] = w_nxt[i];
        end
    end

    assign o_occ     = r_occ;
    assign o_head    = r_slots[0];
    assign o_nxt_occ = w_nxt_occ;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_occ <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_slots[i] <= EMPTY_SLOT;
            end
        end else begin
            r_occ <= w_nxt_occ;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_slots[i] <= w_nxt[i];
            end
        end
    end
endmodule

// File: rtl/buffer_status_core.sv
// Upstream state engine for the buffer-visualisation display: four packet queues,
// read service, statistics, input/read history and a frame-coherent snapshot.
module buffer_status_core
    import buffer_status_pkg::*;
(
    input  logic                            clk,
    input  logic                            reset_n,
    buffer_status_core_if.slave             bus,
    input  logic                            i_frame_start,
    output logic [NUM_BUF*OCC_W-1:0]        o_occ,
    output logic [NUM_BUF*DEPTH*DATA_W-1:0] o_slots,
    output logic [4*DATA_W-1:0]             o_in_hist,
    output logic [4*DATA_W-1:0]             o_rd_hist,
    output logic [CNT_W-1:0]                o_trans_cnt,
    output logic [CNT_W-1:0]                o_recv_cnt,
    output logic [CNT_W-1:0]                o_drop_cnt
);
    logic [OCC_W-1:0]        w_occ       [NUM_BUF];
    logic [DATA_W-1:0]       w_head      [NUM_BUF];
    logic [OCC_W-1:0]        w_nxt_occ   [NUM_BUF];
    logic [DEPTH*DATA_W-1:0] w_nxt_slots [NUM_BUF];
    logic [NUM_BUF-1:0]      w_push;
    logic [NUM_BUF-1:0]      w_pop;
    logic                    w_rd_ok;
    logic                    w_rd_err;
    logic                    w_wr_acc;
    logic [OCC_W-1:0]        w_tail_occ;
    logic [DATA_W-1:0]       w_rd_head;

    logic [CNT_W-1:0]        r_trans, r_recv, r_drop;
    logic [4*DATA_W-1:0]     r_in_hist, r_rd_hist;

    logic [CNT_W-1:0]                w_nxt_trans, w_nxt_recv, w_nxt_drop;
    logic [4*DATA_W-1:0]             w_nxt_in_hist, w_nxt_rd_hist;
    logic [NUM_BUF*OCC_W-1:0]        w_nxt_occ_flat;
    logic [NUM_BUF*DEPTH*DATA_W-1:0] w_nxt_slots_flat;

    // Write acceptance looks at occupancy after any same-cycle read of that queue.
    always_comb begin
        w_pop      = '0;
        w_push     = '0;
        w_rd_head  = w_head[bus.i_rd_buf];
        w_rd_ok    = bus.i_rd_valid && (w_occ[bus.i_rd_buf] != '0);
        w_rd_err   = bus.i_rd_valid && !w_rd_ok;
        w_pop[bus.i_rd_buf] = w_rd_ok;
        w_tail_occ = w_occ[bus.i_wr_buf] - OCC_W'(w_pop[bus.i_wr_buf]);
        w_wr_acc   = bus.i_wr_valid && (w_tail_occ < OCC_W'(DEPTH));
        w_push[bus.i_wr_buf] = w_wr_acc;
    end

    for (genvar q = 0; q < NUM_BUF; q++) begin : g_queue
        buf_queue u_queue (
            .clk         (clk),
            .reset_n     (reset_n),
            .i_push      (w_push[q]),
            .i_pop       (w_pop[q]),
            .i_data      (bus.i_wr_data),
            .o_occ       (w_occ[q]),
            .o_head      (w_head[q]),
            .o_nxt_occ   (w_nxt_occ[q]),
            .o_nxt_slots (w_nxt_slots[q])
        );
    end

    always_comb begin
        w_nxt_recv    = bus.i_wr_valid ? sat_inc(r_recv) : r_recv;
        w_nxt_drop    = (bus.i_wr_valid && !w_wr_acc) ? sat_inc(r_drop) : r_drop;
        w_nxt_trans   = w_rd_ok ? sat_inc(r_trans) : r_trans;
        w_nxt_in_hist = bus.i_wr_valid ? {r_in_hist[3*DATA_W-1:0], bus.i_wr_data} : r_in_hist;
        w_nxt_rd_hist = w_rd_ok ? {r_rd_hist[3*DATA_W-1:0], w_rd_head} : r_rd_hist;
        w_nxt_occ_flat   = '0;
        w_nxt_slots_flat = '0;
        for (int unsigned q = 0; q < NUM_BUF; q++) begin
            w_nxt_occ_flat[q*OCC_W +: OCC_W]                     = w_nxt_occ[q];
            w_nxt_slots_flat[q*DEPTH*DATA_W +: DEPTH*DATA_W]     = w_nxt_slots[q];
        end
    end

    // Snapshot captures the post-update state so a frame_start write is visible at once.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_trans        <= '0;
            r_recv         <= '0;
            r_drop         <= '0;
            r_in_hist      <= '0;
            r_rd_hist      <= '0;
            bus.o_rd_valid <= 1'b0;
            bus.o_rd_data  <= EMPTY_SLOT;
            bus.o_rd_err   <= 1'b0;
            o_occ          <= '0;
            o_slots        <= '0;
            o_in_hist      <= '0;
            o_rd_hist      <= '0;
            o_trans_cnt    <= '0;
            o_recv_cnt     <= '0;
            o_drop_cnt     <= '0;
        end else begin
            r_trans        <= w_nxt_trans;
            r_recv         <= w_nxt_recv;
            r_drop         <= w_nxt_drop;
            r_in_hist      <= w_nxt_in_hist;
            r_rd_hist      <= w_nxt_rd_hist;
            bus.o_rd_valid <= w_rd_ok;
            bus.o_rd_data  <= w_rd_ok ? w_rd_head : EMPTY_SLOT;
            bus.o_rd_err   <= w_rd_err;
            if (i_frame_start) begin
                o_occ       <= w_nxt_occ_flat;
                o_slots     <= w_nxt_slots_flat;
                o_in_hist   <= w_nxt_in_hist;
                o_rd_hist   <= w_nxt_rd_hist;
                o_trans_cnt <= w_nxt_trans;
                o_recv_cnt  <= w_nxt_recv;
                o_drop_cnt  <= w_nxt_drop;
            end
        end
    end
endmodule

// File: tb/tb_buffer_status_core.sv
// Self-checking bench for buffer_status_core: directed scenarios then random traffic,
// compared against a queue-based reference model.
module tb_buffer_status_core;
    import buffer_status_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_frame_start;
    logic [11:0] o_occ;
    logic [95:0] o_slots;
    logic [15:0] o_in_hist, o_rd_hist;
    logic [7:0]  o_trans_cnt, o_recv_cnt, o_drop_cnt;

    buffer_status_core_if bus ();

    buffer_status_core dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus),
        .i_frame_start (i_frame_start),
        .o_occ         (o_occ),
        .o_slots       (o_slots),
        .o_in_hist     (o_in_hist),
        .o_rd_hist     (o_rd_hist),
        .o_trans_cnt   (o_trans_cnt),
        .o_recv_cnt    (o_recv_cnt),
        .o_drop_cnt    (o_drop_cnt)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [3:0]  mq [4][$];
    logic [3:0]  in_l [$];
    logic [3:0]  rd_l [$];
    int          m_recv, m_trans, m_drop;
    logic        e_rv, e_re;
    logic [3:0]  e_rd;
    logic [11:0] e_occ;
    logic [95:0] e_slots;
    logic [15:0] e_in, e_rdh;
    logic [7:0]  e_tr, e_rc, e_dr;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int q = 0; q < 4; q++) mq[q].delete();
        in_l.delete();
        rd_l.delete();
        m_recv = 0; m_trans = 0; m_drop = 0;
        e_rv = 0; e_re = 0; e_rd = 0;
        e_occ = '0; e_slots = '0; e_in = '0; e_rdh = '0;
        e_tr = '0; e_rc = '0; e_dr = '0;
    endtask

    task automatic take_snapshot();
        e_occ = '0; e_slots = '0; e_in = '0; e_rdh = '0;
        for (int q = 0; q < 4; q++) begin
            e_occ[q*3 +: 3] = 3'(mq[q].size());
            for (int s = 0; s < mq[q].size(); s++) e_slots[(q*6+s)*4 +: 4] = mq[q][s];
        end
        for (int i = 0; i < in_l.size(); i++) e_in[i*4 +: 4] = in_l[i];
        for (int i = 0; i < rd_l.size(); i++) e_rdh[i*4 +: 4] = rd_l[i];
        e_tr = 8'(m_trans); e_rc = 8'(m_recv); e_dr = 8'(m_drop);
    endtask

    task automatic model_step();
        logic [3:0] d;
        if (!reset_n) begin
            model_reset();
        end else begin
            e_rv = 0; e_re = 0; e_rd = 0;
            if (bus.i_rd_valid) begin
                if (mq[bus.i_rd_buf].size() > 0) begin
                    d = mq[bus.i_rd_buf].pop_front();
                    e_rv = 1; e_rd = d;
                    m_trans = (m_trans < 255) ? m_trans + 1 : 255;
                    rd_l.push_front(d);
                    if (rd_l.size() > 4) void'(rd_l.pop_back());
                end else begin
                    e_re = 1;
                end
            end
            if (bus.i_wr_valid) begin
                m_recv = (m_recv < 255) ? m_recv + 1 : 255;
                in_l.push_front(bus.i_wr_data);
                if (in_l.size() > 4) void'(in_l.pop_back());
                if (mq[bus.i_wr_buf].size() < 6) mq[bus.i_wr_buf].push_back(bus.i_wr_data);
                else m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            end
            if (i_frame_start) take_snapshot();
        end
    endtask

    task automatic check_all();
        chk("rd_valid", bus.o_rd_valid, e_rv);
        chk("rd_data",  bus.o_rd_data,  e_rd);
        chk("rd_err",   bus.o_rd_err,   e_re);
        chk("occ",      o_occ,          e_occ);
        chk("slots",    o_slots,        e_slots);
        chk("in_hist",  o_in_hist,      e_in);
        chk("rd_hist",  o_rd_hist,      e_rdh);
        chk("trans",    o_trans_cnt,    e_tr);
        chk("recv",     o_recv_cnt,     e_rc);
        chk("drop",     o_drop_cnt,     e_dr);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic wv, input logic [1:0] wb, input logic [3:0] wd,
                         input logic rv, input logic [1:0] rb, input logic fs);
        bus.i_wr_valid = wv; bus.i_wr_buf = wb; bus.i_wr_data = wd;
        bus.i_rd_valid = rv; bus.i_rd_buf = rb; i_frame_start = fs;
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        bus.i_wr_valid = 0; bus.i_wr_buf = 0; bus.i_wr_data = 0;
        bus.i_rd_valid = 0; bus.i_rd_buf = 0; i_frame_start = 0;
        model_reset();
        tick();
        tick();
        chk("reset_occ", o_occ, 12'h000);
        reset_n = 1'b1;

        // Two writes then a frame latch
        drive(1, 2'd0, 4'd3, 0, 2'd0, 0);
        drive(1, 2'd1, 4'd5, 0, 2'd0, 1);
        chk("tp1_occ",  o_occ, {3'd0, 3'd0, 3'd1, 3'd1});
        chk("tp1_q0s0", o_slots[3:0], 4'd3);
        chk("tp1_q1s0", o_slots[27:24], 4'd5);
        chk("tp1_recv", o_recv_cnt, 8'd2);

        // Overfill q2 by one
        for (int i = 1; i <= 7; i++) drive(1, 2'd2, 4'(i), 0, 2'd0, (i == 7));
        chk("tp2_occ2", o_occ[8:6], 3'd6);
        chk("tp2_drop", o_drop_cnt, 8'd1);
        chk("tp2_inh",  o_in_hist[3:0], 4'd7);

        // Full q3: simultaneous read and write
        for (int i = 0; i < 6; i++) drive(1, 2'd3, 4'(10 + i), 0, 2'd0, 0);
        drive(1, 2'd3, 4'd9, 1, 2'd3, 1);
        chk("tp3_rdv",   bus.o_rd_valid, 1'b1);
        chk("tp3_rdd",   bus.o_rd_data, 4'd10);
        chk("tp3_occ3",  o_occ[11:9], 3'd6);
        chk("tp3_slot5", o_slots[95:92], 4'd9);
        chk("tp3_drop",  o_drop_cnt, 8'd1);

        // Drain q1 then read it empty
        drive(0, 2'd0, 4'd0, 1, 2'd1, 0);
        chk("tp4_rd5", bus.o_rd_data, 4'd5);
        drive(0, 2'd0, 4'd0, 1, 2'd1, 1);
        chk("tp4_err",   bus.o_rd_err, 1'b1);
        chk("tp4_rdv",   bus.o_rd_valid, 1'b0);
        chk("tp4_trans", o_trans_cnt, 8'd2);
        drive(0, 2'd0, 4'd0, 0, 2'd0, 0);
        chk("tp4_errclr", bus.o_rd_err, 1'b0);

        // Saturate drop and recv counters
        for (int i = 0; i < 300; i++) drive(1, 2'd2, 4'($urandom_range(0, 15)), 0, 2'd0, (i == 299));
        chk("tp5_drop", o_drop_cnt, 8'd255);
        chk("tp5_recv", o_recv_cnt, 8'd255);

        // Live changes without frame_start leave snapshot frozen
        for (int i = 0; i < 8; i++)
            drive(1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1, 2'($urandom_range(0, 3)), 0);
        chk("tp6_drop_hold", o_drop_cnt, 8'd255);

        // Reset in the middle of a burst
        bus.i_wr_valid = 1; bus.i_wr_buf = 2'd0; bus.i_wr_data = 4'hA;
        bus.i_rd_valid = 1; bus.i_rd_buf = 2'd3; i_frame_start = 1;
        reset_n = 1'b0;
        tick();
        chk("rst_occ",   o_occ, 12'h000);
        chk("rst_slots", o_slots, 96'h0);
        chk("rst_hist",  {o_in_hist, o_rd_hist}, 32'h0);
        chk("rst_cnts",  {o_trans_cnt, o_recv_cnt, o_drop_cnt}, 24'h0);
        chk("rst_rd",    {bus.o_rd_valid, bus.o_rd_err, bus.o_rd_data}, 6'h0);
        reset_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0));
        end
        reset_n = 1'b1;
        drive(0, 2'd0, 4'd0, 0, 2'd0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/buffer_status_core.md
# buffer_status_core

Upstream state engine for the buffer-visualisation VGA display. Accepts incoming 4-bit packets tagged with a destination buffer, holds them in four 6-deep queues, serves read requests, and counts transmitted, received and dropped packets. Publishes a frame-coherent snapshot of all queues, the recent input and read history, and the counters. The VGA pattern generator maps these fields to icons.

## Interface
- NUM_BUF, 4, number of queues (fixed by display layout)
- DEPTH, 6, slots per queue
- DATA_W, 4, packet payload width
- CNT_W, 8, width of each statistics counter
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  synchronous, active-low reset
- i_wr_valid  in  1  incoming packet strobe, one packet per cycle
- i_wr_buf  in  2  destination queue index
- i_wr_data  in  DATA_W  packet payload
- i_rd_valid  in  1  read request strobe
- i_rd_buf  in  2  queue to read
- i_frame_start  in  1  one-cycle pulse at start of vertical blank; snapshot latch
- o_rd_valid  out  1  read response valid
- o_rd_data  out  DATA_W  head packet of the requested queue
- o_rd_err  out  1  read of an empty queue
- o_occ  out  NUM_BUF*3  snapshot occupancy per queue, queue 0 in LSBs
- o_slots  out  NUM_BUF*DEPTH*DATA_W  snapshot contents; queue q slot s at bit offset (q*DEPTH+s)*DATA_W, slot 0 = oldest
- o_in_hist  out  4*DATA_W  snapshot of last 4 accepted or dropped inputs, newest in LSBs
- o_rd_hist  out  4*DATA_W  snapshot of last 4 successful reads, newest in LSBs
- o_trans_cnt, o_recv_cnt, o_drop_cnt  out  CNT_W each  snapshot counters

## Operation
- Each queue is a shift queue. Slot 0 is the head. A read shifts slots down by one, and the vacated top slot clears to 0.
- Slots at index ≥ occupancy always hold 0, which the display renders as an empty icon.
- Receive: every i_wr_valid cycle increments recv_cnt.
- Write acceptance:
  - Accept if the target occupancy, after any same-cycle read of that queue, is < DEPTH.
  - Otherwise drop: the payload is discarded and drop_cnt increments.
- Read:
  - If the queue is non-empty, return the head, shift, decrement occupancy, and increment trans_cnt.
  - If the queue is empty, pulse o_rd_err. o_rd_valid stays low and no counter changes.
- Simultaneous read and write:
  - Same queue: the read is processed first, then the write appends at the new tail. A full queue plus read plus write is accepted, and occupancy stays at 6.
  - Different queues: the two operations are independent.
- History:
  - in_hist shifts in i_wr_data on every i_wr_valid cycle, accepted or dropped.
  - rd_hist shifts in data on every successful read.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Snapshot: on a cycle with i_frame_start high, all o_occ, o_slots, o_*_hist and o_*_cnt load the live state as it will be after that cycle's updates. They hold otherwise, so the display never tears mid-frame.
- Reset:
  - All queues, occupancies, histories, counters and snapshot outputs clear to 0.
  - o_rd_valid and o_rd_err clear to 0.
  - Reset has priority over all inputs, including mid-operation.

## Timing
- Live state updates on the rising clk edge after the strobe cycle.
- o_rd_valid, o_rd_data and o_rd_err are registered, with 1-cycle latency after i_rd_valid. Outside a valid response, o_rd_data is held at 0.
- Snapshot outputs change only on the edge that samples i_frame_start=1. A write in cycle N with i_frame_start also in cycle N is visible in the snapshot at N+1.
- No backpressure: every strobe is resolved in the cycle it is presented.

## Structure
- Shared package buffer_status_pkg holds:
  - constants NUM_BUF, DEPTH, DATA_W, CNT_W and OCC_W=3
  - the empty-slot code 0
  - a saturating-increment function reused by the VGA block's counter rendering.
- One sub-module, buf_queue: a single DEPTH-deep shift queue with push, pop, occupancy and flattened slot outputs, instantiated NUM_BUF times.
- Counters, histories and snapshot registers live in the top.

## Test plan
- Reset, then write 3→q0, 5→q1 and pulse i_frame_start:
  - o_occ = {0,0,1,1}.
  - q0 slot0 = 3, q1 slot0 = 5.
  - recv = 2, trans = 0, drop = 0.
- Write 7 packets to q2:
  - The 7th is dropped: drop = 1 and occ[q2] = 6.
  - in_hist newest nibble = 7th payload.
- Fill q3 to 6, then in one cycle read q3 and write 9→q3:
  - o_rd_data = first payload one cycle later.
  - occ stays 6, slot5 = 9, drop unchanged.
- Read empty q1:
  - o_rd_err = 1 for one cycle, o_rd_valid = 0.
  - trans unchanged.
- Drive 300 writes to a full queue:
  - drop_cnt saturates at 255.
  - recv_cnt saturates at 255.
- Change state without i_frame_start:
  - Snapshot outputs stay constant.
  - Assert reset_n=0 mid-burst: all outputs are 0 on the next edge.
